// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg
//   Shared definitions for the UART ALU command protocol, used by the host
//   initiator, the device side and the ALU itself.
//   Contents: default word/opcode widths, ALU opcode constants, and the
//   host initiator state encoding.
//   Ports: none (package).
package uart_alu_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int OPCODE_SZ_DEF  = 6;

  // ALU function codes (MIPS funct-style encoding).
  localparam logic [OPCODE_SZ_DEF-1:0] OP_ADD = 6'h20;
  localparam logic [OPCODE_SZ_DEF-1:0] OP_SUB = 6'h22;
  localparam logic [OPCODE_SZ_DEF-1:0] OP_AND = 6'h24;
  localparam logic [OPCODE_SZ_DEF-1:0] OP_OR  = 6'h25;
  localparam logic [OPCODE_SZ_DEF-1:0] OP_XOR = 6'h26;
  localparam logic [OPCODE_SZ_DEF-1:0] OP_NOR = 6'h27;
  localparam logic [OPCODE_SZ_DEF-1:0] OP_SRL = 6'h02;
  localparam logic [OPCODE_SZ_DEF-1:0] OP_SRA = 6'h03;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND_OPC = 3'd1,
    ST_SEND_A   = 3'd2,
    ST_SEND_B   = 3'd3,
    ST_WAIT_RES = 3'd4
  } host_state_t;

endpackage

// File: rtl/uart_alu_host_if.sv
// uart_alu_host_if
//   Bundles the front-end request/response signals and the UART FIFO
//   handshake of the host initiator.
//   Front end : i_start, i_opcode, i_op_a, i_op_b -> o_result, o_done,
//               o_busy, o_timeout
//   UART FIFOs: i_tx_full, o_wr_uart, o_w_data (TX side);
//               i_rx_empty, i_r_data, o_rd_uart (RX side, first-word-fall-through)
//   Modports  : master = the host initiator, slave = its environment.
interface uart_alu_host_if
  import uart_alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OPCODE_SZ  = OPCODE_SZ_DEF
);

  logic                  i_start;
  logic [OPCODE_SZ-1:0]  i_opcode;
  logic [DATA_WIDTH-1:0] i_op_a;
  logic [DATA_WIDTH-1:0] i_op_b;
  logic                  i_tx_full;
  logic                  i_rx_empty;
  logic [DATA_WIDTH-1:0] i_r_data;
  logic                  o_wr_uart;
  logic [DATA_WIDTH-1:0] o_w_data;
  logic                  o_rd_uart;
  logic [DATA_WIDTH-1:0] o_result;
  logic                  o_done;
  logic                  o_busy;
  logic                  o_timeout;

  modport master (
    input  i_start, i_opcode, i_op_a, i_op_b, i_tx_full, i_rx_empty, i_r_data,
    output o_wr_uart, o_w_data, o_rd_uart, o_result, o_done, o_busy, o_timeout
  );

  modport slave (
    output i_start, i_opcode, i_op_a, i_op_b, i_tx_full, i_rx_empty, i_r_data,
    input  o_wr_uart, o_w_data, o_rd_uart, o_result, o_done, o_busy, o_timeout
  );

endinterface

// File: rtl/uart_tmo_counter.sv
// uart_tmo_counter
//   Response-wait counter for the host initiator. Clears on i_clear, counts up
//   on i_enable, and flags o_expire while the count sits at LIMIT-1.
//   Ports: i_clk, i_reset (async, active-low), i_clear, i_enable, o_expire.
module uart_tmo_counter
  import uart_alu_pkg::*;
#(
  parameter int LIMIT = 1000000,
  parameter int W     = 20
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  logic [W-1:0] count_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
    end else if (i_clear) begin
      count_q <= '0;
    end else if (i_enable) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign o_expire = (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/uart_alu_host.sv
// uart_alu_host
//   Host-side initiator for the UART ALU command protocol. On an accepted
//   start it latches opcode/A/B, writes the frame {opcode, A, B} into the UART
//   TX FIFO, pops one result byte from the RX FIFO and reports it with a
//   one-cycle done pulse.
//   Ports: i_clk, i_reset (async, active-low), bus (uart_alu_host_if.master).
//   Optional feature: define UART_ALU_HOST_TIMEOUT_EN to abandon the response
//   wait after TIMEOUT_CYCLES clocks with o_timeout; otherwise it waits forever.
module uart_alu_host
  import uart_alu_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int OPCODE_SZ      = OPCODE_SZ_DEF,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TMO_W          = 20
) (
  input  logic            i_clk,
  input  logic            i_reset,
  uart_alu_host_if.master bus
);

  host_state_t           state_q, state_d;
  logic [OPCODE_SZ-1:0]  opc_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, result_q;
  logic                  done_q;
  logic                  load;
  logic                  wr_uart;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  rd_uart;

`ifdef UART_ALU_HOST_TIMEOUT_EN
  logic tmo_expire, tmo_fire, tmo_q;

  // Count only while actually waiting on an empty RX FIFO; restart on the
  // edge that writes B, which is the edge entering WAIT_RES.
  uart_tmo_counter #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TMO_W)
  ) u_tmo (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  ((state_q == ST_SEND_B) && !bus.i_tx_full),
    .i_enable ((state_q == ST_WAIT_RES) && bus.i_rx_empty),
    .o_expire (tmo_expire)
  );
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    wr_uart = 1'b0;
    w_data  = '0;
    rd_uart = 1'b0;
`ifdef UART_ALU_HOST_TIMEOUT_EN
    tmo_fire = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          load    = 1'b1;
          state_d = ST_SEND_OPC;
        end
      end
      // Each SEND state writes its byte only when the FIFO has room and
      // moves on with that write, so every byte goes out exactly once.
      ST_SEND_OPC: begin
        wr_uart = !bus.i_tx_full;
        if (!bus.i_tx_full) begin
          w_data  = DATA_WIDTH'(opc_q);
          state_d = ST_SEND_A;
        end
      end
      ST_SEND_A: begin
        wr_uart = !bus.i_tx_full;
        if (!bus.i_tx_full) begin
          w_data  = a_q;
          state_d = ST_SEND_B;
        end
      end
      ST_SEND_B: begin
        wr_uart = !bus.i_tx_full;
        if (!bus.i_tx_full) begin
          w_data  = b_q;
          state_d = ST_WAIT_RES;
        end
      end
      // A byte present on the expiry cycle takes priority over the timeout.
      ST_WAIT_RES: begin
        rd_uart = !bus.i_rx_empty;
        if (!bus.i_rx_empty) begin
          state_d = ST_IDLE;
        end
`ifdef UART_ALU_HOST_TIMEOUT_EN
        else if (tmo_expire) begin
          tmo_fire = 1'b1;
          state_d  = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      opc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        opc_q <= bus.i_opcode;
        a_q   <= bus.i_op_a;
        b_q   <= bus.i_op_b;
      end
      if (rd_uart) begin
        result_q <= bus.i_r_data;
      end
      done_q <= rd_uart;
    end
  end

`ifdef UART_ALU_HOST_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_fire;
    end
  end
  assign bus.o_timeout = tmo_q;
`else
  assign bus.o_timeout = 1'b0;
`endif

  assign bus.o_wr_uart = wr_uart;
  assign bus.o_w_data  = w_data;
  assign bus.o_rd_uart = rd_uart;
  assign bus.o_result  = result_q;
  assign bus.o_done    = done_q;
  assign bus.o_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_alu_host.sv
// tb_uart_alu_host
//   Directed self-checking bench for uart_alu_host. Drives the front end and
//   acts as the UART FIFOs; a negedge monitor logs every TX write, RX pop,
//   done and timeout pulse.
module tb_uart_alu_host;
  import uart_alu_pkg::*;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] tx_log[$];
  int rd_count      = 0;
  int wr_while_full = 0;
  int tmo_seen      = 0;
  int done_seen     = 0;

  uart_alu_host_if #(.DATA_WIDTH(8), .OPCODE_SZ(6)) bus ();

  uart_alu_host #(
    .DATA_WIDTH     (8),
    .OPCODE_SZ      (6),
    .TIMEOUT_CYCLES (16),
    .TMO_W          (20)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.o_wr_uart) begin
      tx_log.push_back(bus.o_w_data);
      if (bus.i_tx_full) wr_while_full++;
    end
    if (bus.o_rd_uart) rd_count++;
    if (bus.o_timeout) tmo_seen++;
    if (bus.o_done)    done_seen++;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic start, input logic [5:0] opc,
                                input logic [7:0] a, input logic [7:0] b);
    bus.i_start  = start;
    bus.i_opcode = opc;
    bus.i_op_a   = a;
    bus.i_op_b   = b;
  endtask

  // Plays the RX FIFO: once all three bytes are out and the host waits,
  // present resp; stop when done is seen or the budget runs out.
  task automatic serve_response(input logic [7:0] resp, input int base,
                                input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (bus.o_done) begin
        got = 1'b1;
        bus.i_rx_empty = 1'b1;
      end else if (bus.o_busy && !bus.o_wr_uart && (tx_log.size() - base) >= 3
                   && bus.i_rx_empty) begin
        bus.i_rx_empty = 1'b0;
        bus.i_r_data   = resp;
      end
    end
    bus.i_rx_empty = 1'b1;
  endtask

  task automatic check_frame(input string tag, input int base, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2);
    check_output({tag, " frame_len"}, tx_log.size() - base, 3);
    check_output({tag, " byte0"}, tx_log[base], b0);
    check_output({tag, " byte1"}, tx_log[base+1], b1);
    check_output({tag, " byte2"}, tx_log[base+2], b2);
  endtask

  initial begin
    int base;
    int rd0;
    int full0;
    int tmo0;
    int done0;
    bit got;
`ifdef UART_ALU_HOST_TIMEOUT_EN
    int k_tmo;
`endif

    rst_n = 1'b0;
    apply_stimulus(1'b0, 6'h00, 8'h00, 8'h00);
    bus.i_tx_full  = 1'b0;
    bus.i_rx_empty = 1'b1;
    bus.i_r_data   = 8'h00;
    #3;
    check_output("rst busy",    bus.o_busy,    0);
    check_output("rst done",    bus.o_done,    0);
    check_output("rst wr",      bus.o_wr_uart, 0);
    check_output("rst rd",      bus.o_rd_uart, 0);
    check_output("rst result",  bus.o_result,  0);
    check_output("rst timeout", bus.o_timeout, 0);
    step();
    step();
    rst_n = 1'b1;

    // Test 1: basic ADD transaction with cycle-exact latency checks.
    $display("[TB] test 1: basic frame");
    base = tx_log.size();
    rd0  = rd_count;
    step();
    apply_stimulus(1'b1, OP_ADD, 8'h05, 8'h03);
    @(negedge clk);
    check_output("t1 idle busy", bus.o_busy, 0);
    step();
    bus.i_start = 1'b0;
    @(negedge clk);
    check_output("t1 wr opc", bus.o_wr_uart, 1);
    check_output("t1 data opc", bus.o_w_data, 8'h20);
    check_output("t1 busy", bus.o_busy, 1);
    step();
    @(negedge clk);
    check_output("t1 wr a", bus.o_wr_uart, 1);
    check_output("t1 data a", bus.o_w_data, 8'h05);
    step();
    @(negedge clk);
    check_output("t1 wr b", bus.o_wr_uart, 1);
    check_output("t1 data b", bus.o_w_data, 8'h03);
    step();
    @(negedge clk);
    check_output("t1 wait wr", bus.o_wr_uart, 0);
    check_output("t1 wait rd", bus.o_rd_uart, 0);
    check_output("t1 wait busy", bus.o_busy, 1);
    step();
    bus.i_rx_empty = 1'b0;
    bus.i_r_data   = 8'h08;
    @(negedge clk);
    check_output("t1 rd", bus.o_rd_uart, 1);
    step();
    bus.i_rx_empty = 1'b1;
    @(negedge clk);
    check_output("t1 done", bus.o_done, 1);
    check_output("t1 result", bus.o_result, 8'h08);
    check_output("t1 busy after", bus.o_busy, 0);
    step();
    @(negedge clk);
    check_output("t1 done pulse", bus.o_done, 0);
    check_output("t1 result held", bus.o_result, 8'h08);
    check_frame("t1", base, 8'h20, 8'h05, 8'h03);
    check_output("t1 pops", rd_count - rd0, 1);

    // Test 2: TX FIFO full for 10 clocks while in SEND_A.
    $display("[TB] test 2: tx back-pressure");
    base  = tx_log.size();
    rd0   = rd_count;
    full0 = wr_while_full;
    step();
    apply_stimulus(1'b1, OP_SUB, 8'h09, 8'h04);
    step();
    bus.i_start = 1'b0;
    step();
    bus.i_tx_full = 1'b1;
    repeat (10) step();
    check_output("t2 writes during hold", tx_log.size() - base, 1);
    check_output("t2 busy during hold", bus.o_busy, 1);
    bus.i_tx_full = 1'b0;
    serve_response(8'h05, base, 20, got);
    check_output("t2 done seen", got, 1);
    check_output("t2 result", bus.o_result, 8'h05);
    check_frame("t2", base, 8'h22, 8'h09, 8'h04);
    check_output("t2 pops", rd_count - rd0, 1);
    check_output("t2 wr while full", wr_while_full - full0, 0);

    // Test 3: start pulses in SEND_B and WAIT_RES are ignored.
    $display("[TB] test 3: start ignored while busy");
    base = tx_log.size();
    rd0  = rd_count;
    step();
    apply_stimulus(1'b1, OP_XOR, 8'hF0, 8'h0F);
    step();
    bus.i_start = 1'b0;
    step();
    step();
    apply_stimulus(1'b1, 6'h01, 8'h11, 8'h22);
    step();
    apply_stimulus(1'b1, 6'h02, 8'h33, 8'h44);
    step();
    bus.i_start = 1'b0;
    check_output("t3 still waiting", bus.o_busy, 1);
    serve_response(8'hFF, base, 20, got);
    check_output("t3 done seen", got, 1);
    check_output("t3 result", bus.o_result, 8'hFF);
    check_frame("t3", base, 8'h26, 8'hF0, 8'h0F);
    check_output("t3 pops", rd_count - rd0, 1);
    repeat (3) step();
    check_output("t3 no extra frame", tx_log.size() - base, 3);
    check_output("t3 idle after", bus.o_busy, 0);

    // Test 4: asynchronous reset while waiting for the response.
    $display("[TB] test 4: reset mid-transaction");
    step();
    apply_stimulus(1'b1, OP_AND, 8'h3C, 8'h0F);
    step();
    bus.i_start = 1'b0;
    repeat (3) step();
    check_output("t4 in wait", bus.o_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t4 rst busy", bus.o_busy, 0);
    check_output("t4 rst result", bus.o_result, 0);
    check_output("t4 rst done", bus.o_done, 0);
    check_output("t4 rst wr", bus.o_wr_uart, 0);
    check_output("t4 rst wdata", bus.o_w_data, 0);
    check_output("t4 rst rd", bus.o_rd_uart, 0);
    step();
    step();
    rst_n = 1'b1;
    base = tx_log.size();
    rd0  = rd_count;
    step();
    apply_stimulus(1'b1, OP_OR, 8'h50, 8'h0A);
    step();
    bus.i_start = 1'b0;
    serve_response(8'h5A, base, 20, got);
    check_output("t4 done seen", got, 1);
    check_output("t4 result", bus.o_result, 8'h5A);
    check_frame("t4", base, 8'h25, 8'h50, 8'h0A);
    check_output("t4 pops", rd_count - rd0, 1);

`ifdef UART_ALU_HOST_TIMEOUT_EN
    // Test 5: response timeout after 16 clocks, then a byte on the expiry cycle.
    $display("[TB] test 5: response timeout");
    base  = tx_log.size();
    rd0   = rd_count;
    tmo0  = tmo_seen;
    done0 = done_seen;
    step();
    apply_stimulus(1'b1, OP_SRL, 8'h10, 8'h01);
    step();
    bus.i_start = 1'b0;
    repeat (3) step();
    k_tmo = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus.o_timeout && k_tmo < 0) k_tmo = k;
    end
    check_output("t5 timeout delay", k_tmo, 16);
    check_output("t5 timeout pulses", tmo_seen - tmo0, 1);
    check_output("t5 no pop", rd_count - rd0, 0);
    check_output("t5 no done", done_seen - done0, 0);
    check_output("t5 result kept", bus.o_result, 8'h5A);
    check_output("t5 idle", bus.o_busy, 0);
    tmo0 = tmo_seen;
    step();
    apply_stimulus(1'b1, OP_SRA, 8'h80, 8'h01);
    step();
    bus.i_start = 1'b0;
    repeat (3) step();
    repeat (15) step();
    bus.i_rx_empty = 1'b0;
    bus.i_r_data   = 8'hAA;
    step();
    bus.i_rx_empty = 1'b1;
    check_output("t5 late done", bus.o_done, 1);
    check_output("t5 late timeout", bus.o_timeout, 0);
    check_output("t5 late result", bus.o_result, 8'hAA);
    step();
    check_output("t5 no timeout after", tmo_seen - tmo0, 0);
`else
    // Test 6: without the timeout feature the host waits indefinitely.
    $display("[TB] test 6: unbounded wait");
    base = tx_log.size();
    rd0  = rd_count;
    tmo0 = tmo_seen;
    step();
    apply_stimulus(1'b1, OP_ADD, 8'h7F, 8'h00);
    step();
    bus.i_start = 1'b0;
    repeat (3) step();
    repeat (10000) step();
    check_output("t6 still busy", bus.o_busy, 1);
    check_output("t6 no timeout", tmo_seen - tmo0, 0);
    check_output("t6 no pop", rd_count - rd0, 0);
    serve_response(8'h7F, base, 20, got);
    check_output("t6 done seen", got, 1);
    check_output("t6 result", bus.o_result, 8'h7F);
    check_frame("t6", base, 8'h20, 8'h7F, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
